// File: rtl/trace_sample_strobe_gen_if.sv
// Capture-side bus of the trace sample strobe generator: run control in,
// strobe / write word / status out.
interface trace_sample_strobe_gen_if #(
  parameter int unsigned VECTOR_DATA_WIDTH    = 192,
  parameter int unsigned TRACE_BUF_DATA_WIDTH = 256
);
  logic [VECTOR_DATA_WIDTH-1:0]    vector_data;
  logic                            start;
  logic                            stop;
  logic [31:0]                     sample_count;
  logic                            rd_en_100ns;
  logic [TRACE_BUF_DATA_WIDTH-1:0] trace_buf_din;
  logic [31:0]                     samples_written;
  logic                            busy;
  logic                            done;
  logic                            wrapped;

  modport master (
    output vector_data, start, stop, sample_count,
    input  rd_en_100ns, trace_buf_din, samples_written, busy, done, wrapped
  );

  modport slave (
    input  vector_data, start, stop, sample_count,
    output rd_en_100ns, trace_buf_din, samples_written, busy, done, wrapped
  );
endinterface

// File: rtl/trace_sample_strobe_gen.sv
// Divides clk into a periodic sample strobe and captures {timestamp, vector}
// as the trace-buffer write word, with start/stop/count-limit run control.
module trace_sample_strobe_gen #(
  parameter int unsigned VECTOR_DATA_WIDTH    = 192,
  parameter int unsigned TRACE_BUF_DATA_WIDTH = 256,
  parameter int unsigned TRACE_BUF_ADDR_WIDTH = 15,
  parameter int unsigned SAMPLE_DIV           = 10
) (
  input logic                     clk,
  input logic                     rst,
  trace_sample_strobe_gen_if.slave bus
);
  localparam int unsigned TS_WIDTH = TRACE_BUF_DATA_WIDTH - VECTOR_DATA_WIDTH;
  localparam int unsigned DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_TERM   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [32:0]      WRAP_COUNT = 33'(1) << TRACE_BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          r_state;
  logic [DIV_W-1:0]                r_div_cnt;
  logic [63:0]                     r_ts;
  logic                            r_rd_en;
  logic [TRACE_BUF_DATA_WIDTH-1:0] r_din;
  logic [31:0]                     r_samples;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_wrapped;
  logic [31:0]                     w_samples_next;
  logic [TS_WIDTH-1:0]             w_ts_field;

  assign w_samples_next = r_samples + 32'd1;
  assign w_ts_field     = TS_WIDTH'(r_ts);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_ts      <= '0;
      r_rd_en   <= 1'b0;
      r_din     <= '0;
      r_samples <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_rd_en <= 1'b0;
          // stop only vetoes a start from IDLE; in DONE it is ignored
          if (bus.start && (r_state == S_DONE || !bus.stop)) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_div_cnt <= '0;
            r_ts      <= '0;
            r_samples <= '0;
            r_wrapped <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_rd_en <= 1'b0;
          end else begin
            r_ts <= r_ts + 64'd1;
            if (r_div_cnt == DIV_TERM) begin
              r_div_cnt <= '0;
              r_rd_en   <= 1'b1;
              r_din     <= {w_ts_field, bus.vector_data};
              r_samples <= w_samples_next;
              if ({1'b0, w_samples_next} == WRAP_COUNT) r_wrapped <= 1'b1;
              if (bus.sample_count != 32'd0 && w_samples_next == bus.sample_count) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
              r_rd_en   <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en_100ns     = r_rd_en;
  assign bus.trace_buf_din   = r_din;
  assign bus.samples_written = r_samples;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.wrapped         = r_wrapped;
endmodule

// File: tb/tb_trace_sample_strobe_gen.sv
// Bench for trace_sample_strobe_gen: randomized runs against an arithmetic
// model (strobe k lands k*DIV edges after start, timestamp = edge index - 1).
module tb_trace_sample_strobe_gen;
  localparam int unsigned VW  = 192;
  localparam int unsigned DW  = 256;
  localparam int unsigned DIV = 10;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] exp_din;

  always #5 clk = ~clk;

  trace_sample_strobe_gen_if #(.VECTOR_DATA_WIDTH(VW), .TRACE_BUF_DATA_WIDTH(DW)) bus ();
  trace_sample_strobe_gen_if #(.VECTOR_DATA_WIDTH(VW), .TRACE_BUF_DATA_WIDTH(DW)) bus2 ();

  trace_sample_strobe_gen #(
    .VECTOR_DATA_WIDTH(VW), .TRACE_BUF_DATA_WIDTH(DW),
    .TRACE_BUF_ADDR_WIDTH(15), .SAMPLE_DIV(DIV)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  trace_sample_strobe_gen #(
    .VECTOR_DATA_WIDTH(VW), .TRACE_BUF_DATA_WIDTH(DW),
    .TRACE_BUF_ADDR_WIDTH(4), .SAMPLE_DIV(2)
  ) dut_w (.clk(clk), .rst(rst), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] rand_vector();
    logic [VW-1:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // status = {rd_en, busy, done, wrapped, samples_written}
  task automatic chk_status(input string name, input logic [35:0] exp);
    logic [35:0] act;
    act = {bus.rd_en_100ns, bus.busy, bus.done, bus.wrapped, bus.samples_written};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s status {rd,busy,done,wrap,cnt}: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_din(input string name);
    n_vec++;
    if (bus.trace_buf_din !== exp_din) begin
      n_err++;
      $display("FAIL %s din: got %h expected %h at %0t", name, bus.trace_buf_din, exp_din, $time);
    end
  endtask

  // One capture run from IDLE/DONE; stop_at=0 means never stop inside the loop.
  task automatic run_seq(input string name, input int unsigned count, input int unsigned stop_at,
                         input int unsigned ncyc, input bit rand_vec, input bit poke);
    int unsigned k;
    bit running;
    logic [VW-1:0] v;
    logic exp_rd;
    bus.sample_count = count;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    tick();
    bus.start = 1'b0;
    k = 0;
    running = 1'b1;
    chk_status({name, "_start"}, {1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
    for (int unsigned n = 1; n <= ncyc; n++) begin
      v = rand_vec ? rand_vector() : {24{8'hA5}};
      bus.vector_data = v;
      bus.stop  = (n == stop_at) || (!running && poke && $urandom_range(3) == 0);
      bus.start = running && poke && (n != stop_at) && ($urandom_range(7) == 0);
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      exp_rd = 1'b0;
      if (running) begin
        if (n == stop_at) running = 1'b0;
        else if (n % DIV == 0) begin
          k++;
          exp_rd = 1'b1;
          exp_din = {64'(n - 1), v};
          if (count != 0 && k == count) running = 1'b0;
        end
      end
      chk_status(name, {exp_rd, running, !running, 1'b0, 32'(k)});
      chk_din(name);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_status({name, "_end"}, {1'b0, 1'b0, 1'b1, 1'b0, 32'(k)});
    chk_din({name, "_end"});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.sample_count = '0; bus.vector_data = '0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.sample_count = '0; bus2.vector_data = '0;
    tick(); tick();
    exp_din = '0;
    chk_status("reset", '0);
    chk_din("reset");
    rst = 1'b0;
    tick();
    chk_status("after_reset", '0);
  endtask

  task automatic test_start_stop_idle();
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk_status("idle_start_stop", '0);
      tick();
    end
    chk_din("idle_start_stop");
  endtask

  task automatic test_basic();
    run_seq("basic", 0, 0, 35, 1'b0, 1'b0);
  endtask

  task automatic test_count_limit();
    run_seq("count_limit", 3, 0, 45, 1'b1, 1'b0);
  endtask

  task automatic test_stop_terminal();
    run_seq("stop_terminal", 0, 20, 30, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      run_seq("random", $urandom_range(5), ($urandom_range(1) == 1) ? $urandom_range(60, 1) : 0,
              $urandom_range(70, 20), 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bus.sample_count = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 53; i++) tick();
    chk_status("pre_reset_run", {1'b0, 1'b1, 1'b0, 1'b0, 32'd5});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_din = '0;
    chk_status("mid_reset", '0);
    chk_din("mid_reset");
    for (int i = 0; i < 35; i++) begin
      tick();
      chk_status("post_reset_quiet", '0);
    end
    chk_din("post_reset_quiet");
  endtask

  task automatic test_wrap();
    logic [34:0] act;
    logic [34:0] exp;
    int unsigned k;
    bus2.sample_count = 0;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int unsigned n = 1; n <= 40; n++) begin
      tick();
      k = n / 2;
      exp = {(n % 2 == 0), 1'b1, (k >= 16), 32'(k)};
      act = {bus2.rd_en_100ns, bus2.busy, bus2.wrapped, bus2.samples_written};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL wrap_run {rd,busy,wrap,cnt}: got %h expected %h at cycle %0d", act, exp, n);
      end
    end
    bus2.stop = 1'b1;
    tick();
    bus2.stop = 1'b0;
    act = {bus2.done, bus2.busy, bus2.wrapped, bus2.samples_written};
    exp = {1'b1, 1'b0, 1'b1, 32'd20};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL wrap_stop {done,busy,wrap,cnt}: got %h expected %h", act, exp);
    end
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    act = {bus2.done, bus2.busy, bus2.wrapped, bus2.samples_written};
    exp = {1'b0, 1'b1, 1'b0, 32'd0};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL wrap_restart {done,busy,wrap,cnt}: got %h expected %h", act, exp);
    end
    bus2.stop = 1'b1;
    tick();
    bus2.stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_stop_idle();
    test_basic();
    test_count_limit();
    test_stop_terminal();
    test_random();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
